// File: rtl/tetris_pkg.sv
// rtl/tetris_pkg.sv - shared Tetris board types, board geometry and piece palette
package tetris_pkg;

  localparam int BOARD_W = 10;
  localparam int BOARD_H = 20;

  typedef logic [2:0]  cell_t;
  typedef logic [11:0] rgb12_t;

  localparam rgb12_t GRID_EMPTY = 12'h222;

  typedef struct packed {
    logic       active;
    logic       in_board;
    logic       in_frame;
    logic       grid_x;
    logic       grid_y;
    logic       hs;
    logic       vs;
    logic [3:0] col;
    logic [4:0] row;
  } s1_t;

  typedef struct packed {
    logic active;
    logic in_board;
    logic in_frame;
    logic grid;
    logic hs;
    logic vs;
  } s2_t;

  // Entry 0 is the empty cell; callers substitute their own background for it.
  function automatic rgb12_t palette(input cell_t c);
    case (c)
      3'd1:    palette = 12'h0FF;
      3'd2:    palette = 12'hFF0;
      3'd3:    palette = 12'hA0F;
      3'd4:    palette = 12'h0F0;
      3'd5:    palette = 12'hF00;
      3'd6:    palette = 12'h00F;
      3'd7:    palette = 12'hF80;
      default: palette = 12'h000;
    endcase
  endfunction

endpackage

// File: rtl/tetris_palette.sv
// rtl/tetris_palette.sv - cell colour lookup with gridline darkening
module tetris_palette
  import tetris_pkg::*;
#(
  parameter rgb12_t BG_COLOR = 12'h000
) (
  input  cell_t  cell_i,
  input  logic   grid_i,
  output rgb12_t rgb_o
);

  rgb12_t base;

  always_comb begin
    base  = (cell_i == 3'd0) ? BG_COLOR : palette(cell_i);
    rgb_o = base;
    if (grid_i) begin
      // Occupied cells keep their hue on gridlines at half intensity per channel.
      rgb_o = (cell_i == 3'd0) ? GRID_EMPTY
                               : {1'b0, base[11:9], 1'b0, base[7:5], 1'b0, base[3:1]};
    end
  end

endmodule

// File: rtl/board_pixel_renderer.sv
// rtl/board_pixel_renderer.sv - 3-stage pixel pipeline drawing the Tetris board
module board_pixel_renderer
  import tetris_pkg::*;
#(
  parameter int     BOARD_X0    = 480,
  parameter int     BOARD_Y0    = 80,
  parameter int     CELL_SHIFT  = 5,
  parameter int     FRAME_W     = 4,
  parameter rgb12_t BG_COLOR    = 12'h000,
  parameter rgb12_t FRAME_COLOR = 12'h888
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] curr_x,
  input  logic [9:0]  curr_y,
  input  logic        active_area,
  input  logic        hsync_in,
  input  logic        vsync_in,
  output logic [7:0]  cell_addr,
  input  logic [2:0]  cell_data,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        frame_start
);

  localparam int BOARD_PX_W = BOARD_W << CELL_SHIFT;
  localparam int BOARD_PX_H = BOARD_H << CELL_SHIFT;

  localparam logic [10:0] X_LO  = 11'(BOARD_X0);
  localparam logic [10:0] X_HI  = 11'(BOARD_X0 + BOARD_PX_W - 1);
  localparam logic [10:0] FX_LO = 11'(BOARD_X0 - FRAME_W);
  localparam logic [10:0] FX_HI = 11'(BOARD_X0 + BOARD_PX_W - 1 + FRAME_W);
  localparam logic [9:0]  Y_LO  = 10'(BOARD_Y0);
  localparam logic [9:0]  Y_HI  = 10'(BOARD_Y0 + BOARD_PX_H - 1);
  localparam logic [9:0]  FY_LO = 10'(BOARD_Y0 - FRAME_W);
  localparam logic [9:0]  FY_HI = 10'(BOARD_Y0 + BOARD_PX_H - 1 + FRAME_W);
  localparam logic [10:0] MASK_X = 11'((1 << CELL_SHIFT) - 1);
  localparam logic [9:0]  MASK_Y = 10'((1 << CELL_SHIFT) - 1);

  s1_t s1_d, s1_q;
  s2_t s2_q;
  rgb12_t rgb_d, rgb_q, pal_rgb;
  logic hs3_q, vs3_q, vs_prev_q, frame_start_q;
  logic in_board_c, in_rect_c;
  logic [10:0] x_off;
  logic [9:0]  y_off;
  logic [7:0]  row8;

  // Range checks come before the subtraction so offsets are only used when non-negative.
  always_comb begin
    in_board_c = (curr_x >= X_LO) && (curr_x <= X_HI) && (curr_y >= Y_LO) && (curr_y <= Y_HI);
    in_rect_c  = (curr_x >= FX_LO) && (curr_x <= FX_HI) && (curr_y >= FY_LO) && (curr_y <= FY_HI);
    x_off      = curr_x - X_LO;
    y_off      = curr_y - Y_LO;

    s1_d          = '0;
    s1_d.active   = active_area;
    s1_d.in_board = in_board_c;
    s1_d.in_frame = in_rect_c & ~in_board_c;
    s1_d.grid_x   = (x_off & MASK_X) == 11'd0;
    s1_d.grid_y   = (y_off & MASK_Y) == 10'd0;
    s1_d.hs       = hsync_in;
    s1_d.vs       = vsync_in;
    if (in_board_c) begin
      s1_d.col = 4'(x_off >> CELL_SHIFT);
      s1_d.row = 5'(y_off >> CELL_SHIFT);
    end
  end

  assign row8      = {3'b000, s1_q.row};
  assign cell_addr = (row8 << 3) + (row8 << 1) + {4'b0000, s1_q.col};

  tetris_palette #(
    .BG_COLOR(BG_COLOR)
  ) u_palette (
    .cell_i(cell_data),
    .grid_i(s2_q.grid),
    .rgb_o (pal_rgb)
  );

  always_comb begin
    rgb_d = pal_rgb;
    if (!s2_q.active)        rgb_d = 12'h000;
    else if (s2_q.in_frame)  rgb_d = FRAME_COLOR;
    else if (!s2_q.in_board) rgb_d = BG_COLOR;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q          <= '0;
      s1_q.hs       <= 1'b1;
      s2_q          <= '0;
      s2_q.hs       <= 1'b1;
      rgb_q         <= '0;
      hs3_q         <= 1'b1;
      vs3_q         <= 1'b0;
      vs_prev_q     <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      s1_q          <= s1_d;
      s2_q.active   <= s1_q.active;
      s2_q.in_board <= s1_q.in_board;
      s2_q.in_frame <= s1_q.in_frame;
      s2_q.grid     <= s1_q.grid_x | s1_q.grid_y;
      s2_q.hs       <= s1_q.hs;
      s2_q.vs       <= s1_q.vs;
      rgb_q         <= rgb_d;
      hs3_q         <= s2_q.hs;
      vs3_q         <= s2_q.vs;
      vs_prev_q     <= vsync_in;
      frame_start_q <= vsync_in & ~vs_prev_q;
    end
  end

  assign vga_r       = rgb_q[11:8];
  assign vga_g       = rgb_q[7:4];
  assign vga_b       = rgb_q[3:0];
  assign hsync_out   = hs3_q;
  assign vsync_out   = vs3_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_board_pixel_renderer.sv
// tb/tb_board_pixel_renderer.sv - randomized and directed checks against a pixel-level model
module tb_board_pixel_renderer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] curr_x;
  logic [9:0]  curr_y;
  logic        active_area, hsync_in, vsync_in;
  logic [7:0]  cell_addr;
  logic [2:0]  cell_data;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        hsync_out, vsync_out, frame_start;

  always #5 clk = ~clk;

  board_pixel_renderer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .curr_x     (curr_x),
    .curr_y     (curr_y),
    .active_area(active_area),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .cell_addr  (cell_addr),
    .cell_data  (cell_data),
    .vga_r      (vga_r),
    .vga_g      (vga_g),
    .vga_b      (vga_b),
    .hsync_out  (hsync_out),
    .vsync_out  (vsync_out),
    .frame_start(frame_start)
  );

  logic [2:0] mem [0:199];
  always @(posedge clk) cell_data <= (cell_addr < 8'd200) ? mem[cell_addr] : 3'd0;

  logic [11:0] pal [0:7] = '{12'h000, 12'h0FF, 12'hFF0, 12'hA0F, 12'h0F0, 12'hF00, 12'h00F, 12'hF80};

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit on_board(input int x, input int y);
    return (x >= 480) && (x < 800) && (y >= 80) && (y < 720);
  endfunction

  function automatic int model_addr(input int x, input int y);
    if (!on_board(x, y)) return 0;
    return ((y - 80) / 32) * 10 + (x - 480) / 32;
  endfunction

  function automatic logic [11:0] model_rgb(input int x, input int y, input bit act, input logic [2:0] d);
    int bx, by;
    logic [11:0] c;
    bx = x - 480;
    by = y - 80;
    if (!act) return 12'h000;
    if (on_board(x, y)) begin
      c = pal[d];
      if ((bx % 32 == 0) || (by % 32 == 0)) return (d == 3'd0) ? 12'h222 : ((c >> 1) & 12'h777);
      return c;
    end
    if (bx >= -4 && bx < 324 && by >= -4 && by < 644) return 12'h888;
    return 12'h000;
  endfunction

  typedef struct {
    int         x;
    int         y;
    bit         act;
    bit         hs;
    bit         vs;
    logic [2:0] d;
  } ent_t;

  function automatic ent_t blank();
    ent_t e;
    e.x = 0; e.y = 0; e.act = 1'b0; e.hs = 1'b1; e.vs = 1'b0; e.d = 3'd0;
    return e;
  endfunction

  function automatic ent_t sample(input int x, input int y, input bit a, input bit h, input bit v);
    ent_t e;
    e.x = x; e.y = y; e.act = a; e.hs = h; e.vs = v; e.d = 3'd0;
    return e;
  endfunction

  function automatic ent_t with_data(input ent_t e, input logic [2:0] d);
    ent_t r;
    r = e;
    r.d = d;
    return r;
  endfunction

  // h0: pixel sampled at the last edge; h2: pixel now on the outputs.
  ent_t h0, h1, h2;
  bit   prev_vs, exp_fs;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h0 <= blank(); h1 <= blank(); h2 <= blank();
      prev_vs <= 1'b1;
      exp_fs  <= 1'b0;
    end else begin
      h2 <= h1;
      h1 <= with_data(h0, mem[model_addr(h0.x, h0.y)]);
      h0 <= sample(int'(curr_x), int'(curr_y), active_area, hsync_in, vsync_in);
      exp_fs  <= vsync_in & ~prev_vs;
      prev_vs <= vsync_in;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("rgb", {4'h0, vga_r, vga_g, vga_b}, {4'h0, model_rgb(h2.x, h2.y, h2.act, h2.d)});
      check("hsync", {15'd0, hsync_out}, {15'd0, h2.hs});
      check("vsync", {15'd0, vsync_out}, {15'd0, h2.vs});
      check("frame_start", {15'd0, frame_start}, {15'd0, exp_fs});
      check("cell_addr", {8'd0, cell_addr}, 16'(model_addr(h0.x, h0.y)));
    end
  end

  task automatic drv(input int x, input int y, input bit a, input bit h, input bit v);
    @(posedge clk);
    #1;
    curr_x = 11'(x); curr_y = 10'(y); active_area = a; hsync_in = h; vsync_in = v;
  endtask

  task automatic pix(input string name, input int x, input int y, input bit a, input logic [11:0] exp);
    drv(x, y, a, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check(name, {4'h0, vga_r, vga_g, vga_b}, {4'h0, exp});
  endtask

  int pulses;
  int fx [5] = '{476, 475, 800, 600, 600};
  int fy [5] = '{200, 200, 300, 723, 724};
  logic [11:0] fe [5] = '{12'h888, 12'h000, 12'h888, 12'h888, 12'h000};

  initial begin
    rst_n = 1'b0;
    curr_x = '0; curr_y = '0; active_area = 1'b0; hsync_in = 1'b1; vsync_in = 1'b0;
    for (int i = 0; i < 200; i++) mem[i] = 3'($urandom_range(0, 7));

    @(negedge clk);
    check("reset_rgb", {4'h0, vga_r, vga_g, vga_b}, 16'h0000);
    check("reset_hsync", {15'd0, hsync_out}, 16'd1);
    check("reset_vsync", {15'd0, vsync_out}, 16'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;

    check("model_pin_T", {4'h0, model_rgb(581, 151, 1'b1, 3'd5)}, 16'h0F00);
    check("model_pin_grid", {4'h0, model_rgb(512, 151, 1'b1, 3'd1)}, 16'h0077);
    check("model_pin_addr", 16'(model_addr(581, 151)), 16'd23);

    // hsync delay
    repeat (3) drv(0, 0, 1'b1, 1'b1, 1'b0);
    drv(0, 0, 1'b1, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("hs_before", {15'd0, hsync_out}, 16'd1);
    @(posedge clk);
    @(negedge clk);
    check("hs_after", {15'd0, hsync_out}, 16'd0);
    check("hs_rgb", {4'h0, vga_r, vga_g, vga_b}, 16'h0000);

    // cell lookup
    mem[23] = 3'd5;
    drv(581, 151, 1'b1, 1'b1, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("addr23", {8'd0, cell_addr}, 16'd23);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("cell_Z", {4'h0, vga_r, vga_g, vga_b}, 16'h0F00);

    mem[21] = 3'd1;
    pix("grid_I", 512, 151, 1'b1, 12'h077);
    mem[21] = 3'd0;
    pix("grid_empty", 512, 151, 1'b1, 12'h222);

    for (int i = 0; i < 5; i++) pix("frame_edge", fx[i], fy[i], 1'b1, fe[i]);
    pix("inactive", 581, 151, 1'b0, 12'h000);

    // vsync rise held high
    repeat (3) drv(0, 0, 1'b0, 1'b1, 1'b0);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      drv(0, 0, 1'b0, 1'b1, 1'b1);
      @(negedge clk);
      if (frame_start) pulses++;
    end
    check("fs_pulses", 16'(pulses), 16'd1);

    // reset mid-line on a frame pixel
    repeat (4) drv(476, 200, 1'b1, 1'b0, 1'b1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_rgb", {4'h0, vga_r, vga_g, vga_b}, 16'h0000);
    check("mid_rst_hs", {15'd0, hsync_out}, 16'd1);
    check("mid_rst_vs", {15'd0, vsync_out}, 16'd0);
    check("mid_rst_fs", {15'd0, frame_start}, 16'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("blank_rgb", {4'h0, vga_r, vga_g, vga_b}, 16'h0000);
      check("blank_hs", {15'd0, hsync_out}, 16'd1);
      check("blank_fs", {15'd0, frame_start}, 16'd0);
      @(posedge clk);
    end
    @(negedge clk);
    check("post_rst_rgb", {4'h0, vga_r, vga_g, vga_b}, 16'h0888);
    check("post_rst_vs", {15'd0, vsync_out}, 16'd1);

    // randomized traffic with occasional resets and board updates
    for (int n = 0; n < 4000; n++) begin
      @(posedge clk);
      #1;
      rst_n = ($urandom_range(0, 599) != 0);
      if ($urandom_range(0, 3) != 0) begin
        curr_x = 11'($urandom_range(440, 840));
        curr_y = 10'($urandom_range(40, 760));
      end else begin
        curr_x = 11'($urandom_range(0, 2047));
        curr_y = 10'($urandom_range(0, 1023));
      end
      active_area = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 19) == 0) hsync_in = ~hsync_in;
      if ($urandom_range(0, 29) == 0) vsync_in = ~vsync_in;
      if ($urandom_range(0, 9) == 0) mem[$urandom_range(0, 199)] = 3'($urandom_range(0, 7));
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
